// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl -- byte-serial memory controller arbitrating an instruction-fetch
// port and a load/store port onto a single 8-bit RAM.
//
// Ports
//   clock, reset        : system clock, synchronous active-high reset
//   if_req/if_addr      : fetch request (always a 4-byte read)
//   if_ready/if_data    : one-cycle completion pulse, fetched word (held)
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata : load/store request
//   ls_ready/ls_rdata   : one-cycle completion pulse, zero-extended load data
//   ram_rw/ram_write/ram_addr : byte-RAM write enable, write data, address
//   ram_read            : byte-RAM combinational read data for ram_addr
//
// One access runs IDLE -> BUSY (one byte per cycle) -> DONE (ready pulse).
// Load/store wins over fetch when both are requested in the same IDLE cycle.
// ---------------------------------------------------------------------------
module mem_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ready,
    output logic [31:0] ls_rdata,
    output logic        ram_rw,
    output logic [7:0]  ram_write,
    input  logic [7:0]  ram_read,
    output logic [31:0] ram_addr
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Latched access descriptor; last is the index of the final byte (n-1).
    typedef struct packed {
        logic        is_ls;
        logic        we;
        logic [1:0]  last;
        logic [31:0] base;
        logic [31:0] wdata;
    } acc_t;

    state_t      state, state_nx;
    acc_t        acc;
    logic [1:0]  cnt;
    logic [31:0] rbuf;
    logic [31:0] rd_merged;
    logic        busy;

    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ls_req || if_req) state_nx = BUSY;
            BUSY:    if (cnt == acc.last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

    // Read word with the byte arriving this cycle folded into lane cnt, so the
    // final byte lands in if_data/ls_rdata on the same edge that enters DONE.
    always_comb begin
        rd_merged = rbuf;
        rd_merged[{cnt, 3'b000} +: 8] = ram_read;
    end

    // Writes are masked during a reset cycle so an aborted store commits no
    // byte beyond those already written.
    assign ram_rw    = busy && acc.we && !reset;
    assign ram_write = ram_rw ? acc.wdata[{cnt, 3'b000} +: 8] : 8'h00;
    assign ram_addr  = busy ? acc.base + {30'b0, cnt} : 32'h0;
    assign if_ready  = (state == DONE) && !acc.is_ls;
    assign ls_ready  = (state == DONE) &&  acc.is_ls;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= 2'd0;
            rbuf     <= 32'h0;
            if_data  <= 32'h0;
            ls_rdata <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt  <= 2'd0;
                    rbuf <= 32'h0;  // unread upper lanes stay zero
                    if (ls_req)
                        acc <= '{is_ls: 1'b1, we: ls_we, last: last_idx(ls_size),
                                 base: ls_addr, wdata: ls_wdata};
                    else if (if_req)
                        acc <= '{is_ls: 1'b0, we: 1'b0, last: 2'd3,
                                 base: if_addr, wdata: 32'h0};
                end
                BUSY: begin
                    cnt  <= cnt + 2'd1;
                    rbuf <= rd_merged;
                    if (cnt == acc.last && !acc.we) begin
                        if (acc.is_ls) ls_rdata <= rd_merged;
                        else           if_data  <= rd_merged;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ready;
    logic [31:0] ls_rdata;
    logic        ram_rw;
    logic [7:0]  ram_write;
    logic [7:0]  ram_read;
    logic [31:0] ram_addr;

    int vectors = 0;
    int miscompares = 0;

    // 256-byte RAM model aliased on ram_addr[7:0]; poke path for preload.
    logic [7:0] mem [256];
    logic       poke;
    logic [7:0] poke_a, poke_d;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (poke)   mem[poke_a] <= poke_d;
        if (ram_rw) mem[ram_addr[7:0]] <= ram_write;
    end
    assign ram_read = mem[ram_addr[7:0]];

    mem_ctrl dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
        .ram_rw(ram_rw), .ram_write(ram_write), .ram_read(ram_read), .ram_addr(ram_addr)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_poke(input logic [7:0] a, input logic [7:0] d);
        poke = 1'b1; poke_a = a; poke_d = d;
        tick();
        poke = 1'b0;
    endtask

    // Present a request for one accepting cycle; returns in BUSY byte 0.
    task automatic req_ls(input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
        tick();
        ls_req = 1'b0;
    endtask

    logic [31:0] wrap_addr [4];

    initial begin
        reset = 1'b1; poke = 1'b0; poke_a = 8'h0; poke_d = 8'h0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;
        wrap_addr[0] = 32'hFFFF_FFFE; wrap_addr[1] = 32'hFFFF_FFFF;
        wrap_addr[2] = 32'h0000_0000; wrap_addr[3] = 32'h0000_0001;

        // Preload while held in reset; requests asserted too (reset wins).
        ls_req = 1'b1; if_req = 1'b1;
        for (int a = 0; a < 256; a++) do_poke(a[7:0], 8'h00);
        do_poke(8'h00, 8'hB7); do_poke(8'h01, 8'hF0);
        do_poke(8'hFE, 8'h11); do_poke(8'hFF, 8'h22);
        for (int a = 8'h40; a < 8'h44; a++) do_poke(a[7:0], 8'h5A);
        ls_req = 1'b0; if_req = 1'b0;
        tick();

        chk("rst_if_ready", {31'b0, if_ready}, 32'h0);
        chk("rst_ls_ready", {31'b0, ls_ready}, 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        chk("rst_ram_rw", {31'b0, ram_rw}, 32'h0);
        chk("rst_ram_write", {24'b0, ram_write}, 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        reset = 1'b0;
        tick();

        // Word fetch from 0: bytes in T+1..T+4, ready in T+5.
        if_req = 1'b1; if_addr = 32'h0;
        tick();
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fetch_addr", ram_addr, i);
            chk("fetch_rw", {31'b0, ram_rw}, 32'h0);
            chk("fetch_noready", {31'b0, if_ready}, 32'h0);
            if (i < 3) tick();
        end
        chk("fetch_data_held", if_data, 32'h0);
        tick();
        chk("fetch_ready", {31'b0, if_ready}, 32'h1);
        chk("fetch_ls_quiet", {31'b0, ls_ready}, 32'h0);
        chk("fetch_data", if_data, 32'h0000_F0B7);
        chk("done_addr", ram_addr, 32'h0);
        tick();
        chk("fetch_ready_drop", {31'b0, if_ready}, 32'h0);

        // Word store then byte load.
        req_ls(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            chk("stw_rw", {31'b0, ram_rw}, 32'h1);
            chk("stw_addr", ram_addr, 32'h10 + i);
            tick();
        end
        chk("stw_ready", {31'b0, ls_ready}, 32'h1);
        chk("stw_rw_off", {31'b0, ram_rw}, 32'h0);
        chk("stw_rdata_kept", ls_rdata, 32'h0);
        chk("stw_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEAD_BEEF);
        tick();
        req_ls(1'b0, 2'd0, 32'h11, 32'h0);
        chk("ldb_addr", ram_addr, 32'h11);
        chk("ldb_rw", {31'b0, ram_rw}, 32'h0);
        tick();
        chk("ldb_ready", {31'b0, ls_ready}, 32'h1);
        chk("ldb_data", ls_rdata, 32'h0000_00BE);
        tick();

        // Unaligned half store.
        req_ls(1'b1, 2'd1, 32'h21, 32'h0000_ABCD);
        chk("sth_w0", {ram_rw, 15'b0, ram_write, ram_addr[7:0]}, {1'b1, 15'b0, 8'hCD, 8'h21});
        tick();
        chk("sth_w1", {ram_rw, 15'b0, ram_write, ram_addr[7:0]}, {1'b1, 15'b0, 8'hAB, 8'h22});
        tick();
        chk("sth_rw_off", {31'b0, ram_rw}, 32'h0);
        chk("sth_ready", {31'b0, ls_ready}, 32'h1);
        chk("sth_mem", {16'b0, mem[8'h22], mem[8'h21]}, 32'h0000_ABCD);
        chk("sth_rdata_kept", ls_rdata, 32'h0000_00BE);
        tick();
        chk("sth_ready_once", {31'b0, ls_ready}, 32'h0);

        // Simultaneous requests: ls first, fetch after returning to IDLE.
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        ls_req = 1'b0;
        chk("arb_ls_first", ram_addr, 32'h10);
        tick();
        chk("arb_ls_ready", {30'b0, ls_ready, if_ready}, 32'h2);
        chk("arb_ls_data", ls_rdata, 32'h0000_00EF);
        tick();
        chk("arb_idle", {ram_addr[30:0], if_ready}, 32'h0);
        tick();
        if_req = 1'b0;
        chk("arb_if_addr", ram_addr, 32'h20);
        tick(); tick(); tick();
        chk("arb_if_last", ram_addr, 32'h23);
        tick();
        chk("arb_if_ready", {30'b0, ls_ready, if_ready}, 32'h1);
        chk("arb_if_data", if_data, 32'h00AB_CD00);
        tick();

        // Address wrap.
        req_ls(1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", ram_addr, wrap_addr[i]);
            tick();
        end
        chk("wrap_ready", {31'b0, ls_ready}, 32'h1);
        chk("wrap_data", ls_rdata, 32'hF0B7_2211);
        chk("wrap_if_kept", if_data, 32'h00AB_CD00);
        tick();

        // Reset during byte 2 of a word store.
        req_ls(1'b1, 2'd2, 32'h40, 32'h1234_5678);
        tick(); tick();
        chk("abort_at_b2", ram_addr, 32'h42);
        reset = 1'b1;
        tick();
        chk("abort_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h5A5A_5678);
        chk("abort_outs", {ram_rw, ls_ready, if_ready, 21'b0, ram_write}, 32'h0);
        chk("abort_addr", ram_addr, 32'h0);
        chk("abort_if_data", if_data, 32'h0);
        chk("abort_ls_rdata", ls_rdata, 32'h0);
        reset = 1'b0;
        tick();
        chk("abort_no_ready", {30'b0, ls_ready, ram_rw}, 32'h0);
        tick();
        chk("abort_mem_final", {mem[8'h43], mem[8'h42]}, 32'h5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
